ctx_xfer: RTL and testbench

Thread context transfer engine for the 8-thread, 24-bit-address core. It acts as the initiator on the register file port. On request it saves one thread's S, X, Y, A to a 4-byte context block in memory, or restores them from such a block. It drives the memory bus while the core is parked, and the scheduler uses it on thread swap-out and swap-in.

---
 rtl/ctx_xfer_pkg.sv | 38 +++
 rtl/ctx_xfer.sv | 151 +++++++++++++++
 tb/tb_ctx_xfer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctx_xfer_pkg.sv
// Shared definitions for the thread context transfer engine: thread count,
// regfile select codes, context block offsets and the engine state encoding.
package ctx_xfer_pkg;

   localparam int unsigned NumThreads = 8;

   // Regfile select codes; 0 means no register selected
   localparam logic [1:0] SelNone = 2'd0;
   localparam logic [1:0] SelX    = 2'd1;
   localparam logic [1:0] SelY    = 2'd2;
   localparam logic [1:0] SelA    = 2'd3;

   // Byte offsets inside a context block
   localparam logic [1:0] CtxS = 2'd0;
   localparam logic [1:0] CtxX = 2'd1;
   localparam logic [1:0] CtxY = 2'd2;
   localparam logic [1:0] CtxA = 2'd3;

   typedef enum logic [3:0] {
      StIdle,
      StSvS,
      StSvX,
      StSvY,
      StSvA,
      StRs0,
      StRs1,
      StRs2,
      StRs3,
      StRs4,
      StDone
   } state_t;

   // Context block address; wraps modulo 2^24
   function automatic logic [23:0] ctx_addr(input logic [23:0] b, input logic [1:0] off);
      return b + {22'd0, off};
   endfunction

endpackage

// File: rtl/ctx_xfer.sv
// Thread context transfer engine: saves a thread's S/X/Y/A to a 4-byte
// context block in memory, or restores them from one. Bus and regfile
// outputs are decoded from the registered state and latched request.
module ctx_xfer
   import ctx_xfer_pkg::*;
(
   input  logic        clk,
   input  logic        RST,
   input  logic        start,
   input  logic        op,
   input  logic [2:0]  thr,
   input  logic [23:0] base,
   input  logic [7:0]  sp,
   output logic        busy,
   output logic        done,
   input  logic        RDY,
   output logic [23:0] AB,
   output logic [7:0]  DO,
   output logic        WE,
   input  logic [7:0]  DI,
   output logic [2:0]  reg_thr,
   output logic [1:0]  reg_src,
   input  logic [7:0]  src,
   output logic [1:0]  reg_dst,
   output logic [7:0]  dst,
   output logic        reg_we,
   output logic        txs
);

   state_t      state_q, state_d;
   logic [2:0]  thr_q;
   logic [23:0] base_q;
   logic        accept;
   logic        stb_en;

   // State register and request fields captured on accept
   always_ff @(posedge clk) begin
      if (RST) begin
         state_q <= StIdle;
         thr_q   <= 3'd0;
         base_q  <= 24'd0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            thr_q  <= thr;
            base_q <= base;
         end
      end
   end

   // Next state: RDY low freezes every non-idle state, DONE included
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      unique case (state_q)
         StIdle: accept = start;
         StSvS:  if (RDY) state_d = StSvX;
         StSvX:  if (RDY) state_d = StSvY;
         StSvY:  if (RDY) state_d = StSvA;
         StSvA:  if (RDY) state_d = StDone;
         StRs0:  if (RDY) state_d = StRs1;
         StRs1:  if (RDY) state_d = StRs2;
         StRs2:  if (RDY) state_d = StRs3;
         StRs3:  if (RDY) state_d = StRs4;
         StRs4:  if (RDY) state_d = StDone;
         StDone: begin
            if (RDY) begin
               state_d = StIdle;
               accept  = start;
            end
         end
         default: state_d = StIdle;
      endcase
      if (accept) state_d = op ? StRs0 : StSvS;
   end

   // Strobes are suppressed while stalled and in the reset cycle so a
   // mid-transfer reset never lands another write
   assign stb_en = RDY & ~RST;

   // Bus and regfile decode of the current state
   always_comb begin
      AB      = 24'd0;
      DO      = 8'd0;
      WE      = 1'b0;
      reg_src = SelNone;
      reg_dst = SelNone;
      dst     = 8'd0;
      reg_we  = 1'b0;
      txs     = 1'b0;
      unique case (state_q)
         StSvS: begin
            AB = ctx_addr(base_q, CtxS);
            DO = sp;
            WE = stb_en;
         end
         StSvX: begin
            AB      = ctx_addr(base_q, CtxX);
            reg_src = SelX;
            DO      = src;
            WE      = stb_en;
         end
         StSvY: begin
            AB      = ctx_addr(base_q, CtxY);
            reg_src = SelY;
            DO      = src;
            WE      = stb_en;
         end
         StSvA: begin
            AB      = ctx_addr(base_q, CtxA);
            reg_src = SelA;
            DO      = src;
            WE      = stb_en;
         end
         StRs0: AB = ctx_addr(base_q, CtxS);
         StRs1: begin
            // S byte parks in X until the next cycle moves it into S
            AB      = ctx_addr(base_q, CtxX);
            reg_dst = SelX;
            dst     = DI;
            reg_we  = stb_en;
         end
         StRs2: begin
            AB      = ctx_addr(base_q, CtxY);
            reg_src = SelX;
            txs     = stb_en;
            reg_dst = SelX;
            dst     = DI;
            reg_we  = stb_en;
         end
         StRs3: begin
            AB      = ctx_addr(base_q, CtxA);
            reg_dst = SelY;
            dst     = DI;
            reg_we  = stb_en;
         end
         StRs4: begin
            AB      = ctx_addr(base_q, CtxA);
            reg_dst = SelA;
            dst     = DI;
            reg_we  = stb_en;
         end
         default: ;
      endcase
   end

   assign busy    = (state_q != StIdle) && (state_q != StDone);
   assign done    = (state_q == StDone);
   assign reg_thr = thr_q;

endmodule

// File: tb/tb_ctx_xfer.sv
// Bench for ctx_xfer: memory and regfile environment models, a transaction
// level golden model, and a scoreboard monitor checking every strobe cycle.
module tb_ctx_xfer;
   import ctx_xfer_pkg::*;

   logic        clk = 1'b0;
   logic        RST = 1'b1;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [2:0]  thr = 3'd0;
   logic [23:0] base = 24'd0;
   logic [7:0]  sp = 8'd0;
   logic        busy, done;
   logic        RDY = 1'b1;
   logic [23:0] AB;
   logic [7:0]  DO;
   logic        WE;
   logic [7:0]  DI = 8'h00;
   logic [2:0]  reg_thr;
   logic [1:0]  reg_src;
   logic [7:0]  src;
   logic [1:0]  reg_dst;
   logic [7:0]  dst;
   logic        reg_we, txs;

   always #5 clk = ~clk;

   ctx_xfer dut (
      .clk(clk), .RST(RST), .start(start), .op(op), .thr(thr), .base(base), .sp(sp),
      .busy(busy), .done(done), .RDY(RDY), .AB(AB), .DO(DO), .WE(WE), .DI(DI),
      .reg_thr(reg_thr), .reg_src(reg_src), .src(src), .reg_dst(reg_dst), .dst(dst),
      .reg_we(reg_we), .txs(txs)
   );

   int errors = 0;
   int checks = 0;

   // Environment: regfile and sparse memory
   logic [7:0] rS[8], rX[8], rY[8], rA[8];
   logic [7:0] mem [logic [23:0]];
   // Golden model
   logic [7:0] gS[8], gX[8], gY[8], gA[8];
   logic [7:0] gmem [logic [23:0]];
   bit         y_unk[8];

   function automatic logic [7:0] mem_rd(input logic [23:0] a);
      return mem.exists(a) ? mem[a] : 8'h00;
   endfunction

   always_comb begin
      case (reg_src)
         SelX:    src = rX[reg_thr];
         SelY:    src = rY[reg_thr];
         SelA:    src = rA[reg_thr];
         default: src = 8'h00;
      endcase
   end

   always @(posedge clk) begin
      if (RDY) DI <= mem_rd(AB);
      if (WE) mem[AB] = DO;
      if (txs) rS[reg_thr] <= src;
      if (reg_we) begin
         case (reg_dst)
            SelX:    rX[reg_thr] <= dst;
            SelY:    rY[reg_thr] <= dst;
            SelA:    rA[reg_thr] <= dst;
            default: ;
         endcase
      end
   end

   typedef struct {
      int          kind;  // 0 mem write, 1 reg write, 2 done
      logic [23:0] addr;
      logic [7:0]  data;
      logic [1:0]  sel;
      logic        tx;
      logic [2:0]  t;
   } ev_t;
   ev_t exp_q[$];

   function automatic ev_t mk(input int k, input logic [23:0] a, input logic [7:0] d,
                              input logic [1:0] s, input logic x, input logic [2:0] t);
      ev_t e;
      e.kind = k; e.addr = a; e.data = d; e.sel = s; e.tx = x; e.t = t;
      return e;
   endfunction

   // Scoreboard monitor
   always @(negedge clk) begin
      ev_t e;
      bit  ok;
      if (!RST) begin
         if (!RDY && busy) begin
            checks++;
            if (WE || reg_we || txs) begin
               errors++;
               $display("FAIL stall_strobe: WE=%b reg_we=%b txs=%b, required all 0", WE, reg_we, txs);
            end
         end
         if (WE || reg_we || txs) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: WE=%b AB=%h DO=%h reg_we=%b, none required",
                        WE, AB, DO, reg_we);
            end else begin
               e = exp_q.pop_front();
               if (e.kind == 0)
                  ok = WE && !reg_we && !txs && AB == e.addr && DO == e.data;
               else
                  ok = (e.kind == 1) && !WE && reg_we && reg_thr == e.t && reg_dst == e.sel &&
                       dst == e.data && txs == e.tx && (!e.tx || reg_src == SelX);
               if (!ok) begin
                  errors++;
                  $display("FAIL access: got WE=%b AB=%h DO=%h we=%b thr=%0d dst_sel=%0d dst=%h txs=%b; required kind=%0d addr=%h data=%h sel=%0d txs=%b thr=%0d",
                           WE, AB, DO, reg_we, reg_thr, reg_dst, dst, txs,
                           e.kind, e.addr, e.data, e.sel, e.tx, e.t);
               end
            end
         end
         if (done && RDY) begin
            checks++;
            if (exp_q.size() == 0 || exp_q[0].kind != 2) begin
               errors++;
               $display("FAIL done_early: done seen with %0d accesses still pending", exp_q.size());
            end else begin
               e = exp_q.pop_front();
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Called at a negedge with the DUT idle or in DONE with RDY high
   task automatic xfer(input logic o, input logic [2:0] t, input logic [23:0] b,
                       input logic [7:0] s, input bit rnd, input int stall_at,
                       input int stall_len, input int exp_lat, input bit poke);
      logic [7:0]  m[4];
      logic [23:0] a;
      int          lat;
      start = 1'b1; op = o; thr = t; base = b; sp = s;
      if (!o) begin
         m[0] = s; m[1] = gX[t]; m[2] = gY[t]; m[3] = gA[t];
         for (int i = 0; i < 4; i++) begin
            a = b + 24'(i);
            exp_q.push_back(mk(0, a, m[i], SelNone, 1'b0, t));
            gmem[a] = m[i];
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            a = b + 24'(i);
            m[i] = gmem.exists(a) ? gmem[a] : 8'h00;
         end
         exp_q.push_back(mk(1, 24'd0, m[0], SelX, 1'b0, t));
         exp_q.push_back(mk(1, 24'd0, m[1], SelX, 1'b1, t));
         exp_q.push_back(mk(1, 24'd0, m[2], SelY, 1'b0, t));
         exp_q.push_back(mk(1, 24'd0, m[3], SelA, 1'b0, t));
         gS[t] = m[0]; gX[t] = m[1]; gY[t] = m[2]; gA[t] = m[3];
         y_unk[t] = 1'b0;
      end
      exp_q.push_back(mk(2, 24'd0, 8'h00, SelNone, 1'b0, t));
      lat = -1;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk);
         #1;
         start = poke && (n == 2);
         if (poke && n == 2) begin
            op = ~o; thr = t + 3'd1; base = b + 24'h000100;
         end
         if (rnd) RDY = ($urandom_range(0, 3) != 0);
         else RDY = !(n >= stall_at && n < stall_at + stall_len);
         @(negedge clk);
         if (done && RDY) begin
            lat = n;
            break;
         end
      end
      if (lat < 0) begin
         errors++;
         $display("FAIL timeout: no done within 100 cycles (op=%b thr=%0d)", o, t);
      end else if (exp_lat > 0) begin
         chk("done_latency", 32'(lat), 32'(exp_lat));
      end
   endtask

   task automatic preload(input logic [23:0] b, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
      logic [7:0] d[4];
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
      for (int i = 0; i < 4; i++) begin
         mem[b + 24'(i)]  = d[i];
         gmem[b + 24'(i)] = d[i];
      end
   endtask

   task automatic rst_test(input logic [2:0] t, input logic [23:0] b);
      logic [7:0] old_a;
      old_a = gA[t];
      preload(b, 8'hA5, 8'h5A, 8'hC3, 8'h3C);
      start = 1'b1; op = 1'b1; thr = t; base = b;
      exp_q.push_back(mk(1, 24'd0, 8'hA5, SelX, 1'b0, t));
      exp_q.push_back(mk(1, 24'd0, 8'h5A, SelX, 1'b1, t));
      for (int n = 1; n <= 4; n++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         RDY = 1'b1;
         if (n == 4) RST = 1'b1;
      end
      @(posedge clk);
      #1;
      RST = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_we", 32'(WE), 32'd0);
      chk("rst_reg_we", 32'(reg_we), 32'd0);
      chk("rst_txs", 32'(txs), 32'd0);
      chk("rst_ab", 32'(AB), 32'd0);
      chk("rst_do", 32'(DO), 32'd0);
      chk("rst_pending", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      chk("rst_S", 32'(rS[t]), 32'h A5);
      chk("rst_X", 32'(rX[t]), 32'h5A);
      chk("rst_A_kept", 32'(rA[t]), 32'(old_a));
      gS[t] = 8'hA5; gX[t] = 8'h5A;
      y_unk[t] = 1'b1;
   endtask

   initial begin
      logic [23:0] b;
      for (int t = 0; t < 8; t++) begin
         rS[t] = 8'($urandom); rX[t] = 8'($urandom);
         rY[t] = 8'($urandom); rA[t] = 8'($urandom);
         if (t == 3) begin
            rX[t] = 8'h04; rY[t] = 8'h08; rA[t] = 8'h43;
         end
         gS[t] = rS[t]; gX[t] = rX[t]; gY[t] = rY[t]; gA[t] = rA[t];
         y_unk[t] = 1'b0;
      end

      repeat (3) @(posedge clk);
      #1 RST = 1'b0;
      @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_we", 32'(WE), 32'd0);
      chk("reset_reg_we", 32'(reg_we), 32'd0);
      chk("reset_txs", 32'(txs), 32'd0);
      chk("reset_ab", 32'(AB), 32'd0);
      chk("reset_do", 32'(DO), 32'd0);

      xfer(1'b0, 3'd3, 24'h001F00, 8'hFF, 1'b0, 0, 0, 5, 1'b0);
      preload(24'h002000, 8'h80, 8'h11, 8'h22, 8'h33);
      xfer(1'b1, 3'd5, 24'h002000, 8'h00, 1'b0, 0, 0, 6, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("restore_S5", 32'(rS[5]), 32'h80);
      chk("restore_X5", 32'(rX[5]), 32'h11);
      chk("restore_Y5", 32'(rY[5]), 32'h22);
      chk("restore_A5", 32'(rA[5]), 32'h33);

      xfer(1'b0, 3'd1, 24'hFFFFFE, 8'h6D, 1'b0, 0, 0, 5, 1'b0);
      preload(24'h003000, 8'h9E, 8'h01, 8'hF0, 8'h7C);
      xfer(1'b1, 3'd6, 24'h003000, 8'h00, 1'b0, 3, 2, 8, 1'b0);
      xfer(1'b0, 3'd2, 24'h001000, 8'h31, 1'b0, 0, 0, 5, 1'b1);
      xfer(1'b1, 3'd0, 24'h001F00, 8'h00, 1'b0, 0, 0, 6, 1'b0);
      @(posedge clk);
      @(negedge clk);

      rst_test(3'd4, 24'h004000);

      for (int k = 0; k < 40; k++) begin
         logic o;
         o = 1'($urandom);
         b = ($urandom_range(0, 3) == 0) ? 24'hFFFFFC + 24'($urandom_range(0, 3))
                                         : 24'($urandom);
         if (o && $urandom_range(0, 1) == 1)
            preload(b, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
         xfer(o, 3'($urandom_range(0, 7)), b, 8'($urandom), 1'b1, 0, 0, 0, 1'b0);
      end
      RDY = 1'b1;
      repeat (2) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      for (int t = 0; t < 8; t++) begin
         chk($sformatf("final_S%0d", t), 32'(rS[t]), 32'(gS[t]));
         chk($sformatf("final_X%0d", t), 32'(rX[t]), 32'(gX[t]));
         if (!y_unk[t]) chk($sformatf("final_Y%0d", t), 32'(rY[t]), 32'(gY[t]));
         chk($sformatf("final_A%0d", t), 32'(rA[t]), 32'(gA[t]));
      end
      foreach (gmem[a]) chk($sformatf("final_mem_%h", a), 32'(mem_rd(a)), 32'(gmem[a]));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
